// File: rtl/display_mode_ctrl.sv
// Two-button display mode controller: synchronizes and debounces the buttons,
// then sequences FULL/SINGLE display modes with a blanking window around each switch.
module display_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLANK_CYCLES    = 100000,
    parameter int TIMEOUT_CYCLES  = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    output logic       mode,
    output logic [2:0] digit_sel,
    output logic       blank,
    output logic       mode_changed
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W = $clog2(BLANK_CYCLES);
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES) > 32) ? $clog2(TIMEOUT_CYCLES) : 32;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_FULL,
        S_BLANK_TO_SINGLE,
        S_SINGLE,
        S_BLANK_TO_FULL
    } state_e;

    // Bit 0 carries the mode button, bit 1 the next button.
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           level_q, level_d;
    logic [1:0]           press_q, press_d;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [2:0]           digit_sel_q, digit_sel_d;
    logic                 mode_changed_q, mode_changed_d;
    logic [BL_W-1:0]      blank_cnt_q, blank_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

    logic                 mode_press, next_press;

    assign mode_press = press_q[0];
    assign next_press = press_q[1];

    // A level is accepted only after the synchronized input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; agreement restarts the count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        level_d  = level_q;
        press_d  = 2'b00;
        db_cnt_d = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    level_d[b] = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        digit_sel_d    = digit_sel_q;
        mode_changed_d = 1'b0;
        blank_cnt_d    = blank_cnt_q;
        to_cnt_d       = to_cnt_q;
        case (state_q)
            S_FULL: begin
                if (mode_press) begin
                    state_d     = S_BLANK_TO_SINGLE;
                    digit_sel_d = 3'd0;
                    blank_cnt_d = '0;
                end
            end
            S_BLANK_TO_SINGLE, S_BLANK_TO_FULL: begin
                // Mode flips one edge into the window; BLANK_CYCLES >= 2 keeps that apart from the exit edge.
                if (blank_cnt_q == '0) begin
                    mode_d         = ~mode_q;
                    mode_changed_d = 1'b1;
                end
                if (blank_cnt_q == BL_LAST) begin
                    state_d  = (state_q == S_BLANK_TO_SINGLE) ? S_SINGLE : S_FULL;
                    to_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BL_W'(1);
                end
            end
            S_SINGLE: begin
                if (mode_press) begin
                    state_d     = S_BLANK_TO_FULL;
                    blank_cnt_d = '0;
                end else if (next_press) begin
                    digit_sel_d = digit_sel_q + 3'd1;
                    to_cnt_d    = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = S_BLANK_TO_FULL;
                    blank_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_FULL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            level_q        <= '0;
            press_q        <= '0;
            db_cnt_q       <= '0;
            state_q        <= S_FULL;
            mode_q         <= 1'b0;
            digit_sel_q    <= 3'd0;
            mode_changed_q <= 1'b0;
            blank_cnt_q    <= '0;
            to_cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync1_q        <= {btn_next, btn_mode};
            sync2_q        <= sync1_q;
            level_q        <= level_d;
            press_q        <= press_d;
            db_cnt_q       <= db_cnt_d;
            state_q        <= state_d;
            mode_q         <= mode_d;
            digit_sel_q    <= digit_sel_d;
            mode_changed_q <= mode_changed_d;
            blank_cnt_q    <= blank_cnt_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign mode         = mode_q;
    assign digit_sel    = digit_sel_q;
    assign blank        = (state_q == S_BLANK_TO_SINGLE) || (state_q == S_BLANK_TO_FULL);
    assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl: stimulus queues expected output changes,
// a monitor pops one per observed change of {mode, digit_sel, blank, mode_changed}.
module tb_display_mode_ctrl;
    localparam int DEB = 4;
    localparam int BLK = 3;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       mode, blank, mode_changed;
    logic [2:0] digit_sel;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [5:0] val;   // {mode, digit_sel, blank, mode_changed}
        bit         rel;   // window relative to previous change, else absolute cycle
        int         lo;
        int         hi;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    display_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BLANK_CYCLES   (BLK),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_next    (btn_next),
        .mode        (mode),
        .digit_sel   (digit_sel),
        .blank       (blank),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input int lo, input int hi);
        checks++;
        if ($isunknown(got) || int'(got) < lo || int'(got) > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic push(input logic [5:0] val, input bit rel, input int lo, input int hi,
                        input string name);
        exp_t e;
        e.val  = val;
        e.rel  = rel;
        e.lo   = lo;
        e.hi   = hi;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Four changes of a mode switch: blank rise, mode toggle + pulse, pulse end, blank fall.
    task automatic push_switch(input bit to_single, input logic [2:0] ds, input bit first_rel,
                               input int lo, input int hi, input string name);
        logic       from_m;
        logic [2:0] d;
        from_m = to_single ? 1'b0 : 1'b1;
        d      = to_single ? 3'd0 : ds;
        push({from_m,  d, 1'b1, 1'b0}, first_rel, lo, hi, {name, " blank rise"});
        push({~from_m, d, 1'b1, 1'b1}, 1'b1, 1, 1, {name, " mode toggle"});
        push({~from_m, d, 1'b1, 1'b0}, 1'b1, 1, 1, {name, " pulse end"});
        push({~from_m, d, 1'b0, 1'b0}, 1'b1, 1, 1, {name, " blank fall"});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drained(input string name);
        check({name, " all expected changes seen"}, exp_q.size(), 0, 0);
    endtask

    // Monitor: every change of the observed tuple is one DUT transaction.
    initial begin
        logic [5:0] prev, cur;
        int         last_cyc, delta;
        exp_t       e;
        wait (mon_en);
        prev     = 6'b0;
        last_cyc = cyc;
        forever begin
            @(negedge clk);
            cur = {mode, digit_sel, blank, mode_changed};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected change at cycle %0d: got %b, expected no change from %b",
                             cyc, cur, prev);
                end else begin
                    e     = exp_q.pop_front();
                    delta = e.rel ? (cyc - last_cyc) : cyc;
                    check({e.name, " value"}, cur, int'(e.val), int'(e.val));
                    check({e.name, " timing"}, delta, e.lo, e.hi);
                end
                prev     = cur;
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        cycles(3);
        check("reset mode", mode, 0, 0);
        check("reset digit_sel", digit_sel, 0, 0);
        check("reset blank", blank, 0, 0);
        check("reset mode_changed", mode_changed, 0, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        cycles(5);

        // Clean press: FULL -> SINGLE.
        k = cyc;
        push_switch(1'b1, 3'd0, 1'b0, k + 5, k + 8, "clean press");
        btn_mode = 1'b1;
        cycles(20);
        btn_mode = 1'b0;
        cycles(12);
        drained("clean press");

        // Digit stepping with wrap: 1..7,0,1 then on to 3.
        for (int i = 1; i <= 11; i++) begin
            k = cyc;
            push({1'b1, 3'(i % 8), 1'b0, 1'b0}, 1'b0, k + 5, k + 8, "next press");
            btn_next = 1'b1;
            cycles(8);
            btn_next = 1'b0;
            cycles(10);
        end
        drained("digit wrap");

        // Simultaneous mode+next in SINGLE: mode wins, digit_sel held at 3.
        k = cyc;
        push_switch(1'b0, 3'd3, 1'b0, k + 5, k + 8, "simultaneous");
        btn_mode = 1'b1;
        btn_next = 1'b1;
        cycles(20);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        cycles(12);
        drained("simultaneous");

        // Next press in FULL is ignored.
        btn_next = 1'b1;
        cycles(10);
        btn_next = 1'b0;
        cycles(12);
        drained("next in full");
        check("next in full digit_sel", digit_sel, 3, 3);

        // Bounce: toggle every 2 cycles for 16 cycles, then low.
        for (int i = 0; i < 8; i++) begin
            btn_mode = ~btn_mode;
            cycles(2);
        end
        btn_mode = 1'b0;
        cycles(20);
        drained("bounce");
        check("bounce mode", mode, 0, 0);
        check("bounce blank", blank, 0, 0);

        // Idle timeout: 50 cycles in SINGLE returns to FULL.
        k = cyc;
        push_switch(1'b1, 3'd0, 1'b0, k + 5, k + 8, "timeout entry");
        push_switch(1'b0, 3'd0, 1'b1, TMO, TMO, "idle timeout");
        btn_mode = 1'b1;
        cycles(20);
        btn_mode = 1'b0;
        cycles(60);
        drained("idle timeout");

        // Next press taking effect 40 cycles into SINGLE restarts the timeout.
        k = cyc;
        push_switch(1'b1, 3'd0, 1'b0, k + 5, k + 8, "delayed entry");
        push({1'b1, 3'd1, 1'b0, 1'b0}, 1'b1, 40, 40, "next at 40");
        push_switch(1'b0, 3'd1, 1'b1, TMO, TMO, "delayed timeout");
        btn_mode = 1'b1;
        cycles(20);
        btn_mode = 1'b0;
        cycles(23);
        btn_next = 1'b1;
        cycles(8);
        btn_next = 1'b0;
        cycles(70);
        drained("delayed timeout");

        // Reset in cycle 2 of BLANK_TO_SINGLE clears outputs without a clock edge.
        k = cyc;
        push({1'b0, 3'd0, 1'b1, 1'b0}, 1'b0, k + 5, k + 8, "mid-blank blank rise");
        push({1'b0, 3'd0, 1'b0, 1'b0}, 1'b1, 1, 1, "mid-blank reset clear");
        btn_mode = 1'b1;
        cycles(7);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        btn_mode = 1'b0;
        #1;
        check("async reset mode", mode, 0, 0);
        check("async reset blank", blank, 0, 0);
        check("async reset mode_changed", mode_changed, 0, 0);
        cycles(2);
        reset = 1'b0;
        cycles(30);
        drained("after mid-blank reset");

        k = cyc;
        push_switch(1'b1, 3'd0, 1'b0, k + 5, k + 8, "press after reset");
        btn_mode = 1'b1;
        cycles(20);
        btn_mode = 1'b0;
        cycles(12);
        drained("press after reset");

        // Button held through reset counts as a fresh press once debounced.
        @(posedge clk);
        #1;
        push({1'b0, 3'd0, 1'b0, 1'b0}, 1'b0, cyc, cyc, "reset from single");
        reset    = 1'b1;
        btn_mode = 1'b1;
        cycles(3);
        k = cyc;
        push_switch(1'b1, 3'd0, 1'b0, k + 5, k + 8, "held through reset");
        reset = 1'b0;
        cycles(20);
        btn_mode = 1'b0;
        cycles(12);
        drained("held through reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_mode_ctrl.md
DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the clock cycles a synchronized button must hold a new level before it is accepted.
REQ-002 SHALL have parameter BLANK_CYCLES, default 100000, meaning the cycles all digits are blanked around a mode switch; legal values are 2 or more.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000000, meaning the idle cycles in single mode before auto-return to full mode.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btn_mode, input, 1 bit: raw, asynchronous mode-toggle button, active-high.
REQ-007 SHALL have port btn_next, input, 1 bit: raw, asynchronous next-digit button, active-high.
REQ-008 SHALL have port mode, output, 1 bit: display mux select; 0 = full display, 1 = single display.
REQ-009 SHALL have port digit_sel, output, 3 bits: digit index shown in single mode.
REQ-010 SHALL have port blank, output, 1 bit: when 1, downstream logic forces all anodes off.
REQ-011 SHALL have port mode_changed, output, 1 bit: one-cycle pulse on every mode toggle.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-013 SHALL change a debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 SHALL generate an internal press pulse, one cycle wide, on each 0->1 change of a debounced level; releases generate nothing.
REQ-015 SHALL implement a 4-state FSM: FULL, BLANK_TO_SINGLE, SINGLE and BLANK_TO_FULL.
REQ-016 SHALL, in FULL on a mode press, enter BLANK_TO_SINGLE; next presses are ignored in FULL.
REQ-017 SHALL, in either BLANK state, assert blank on the entry edge, toggle mode and pulse mode_changed one edge later, and deassert blank after exactly BLANK_CYCLES cycles; the FSM then moves to SINGLE or FULL, respectively.
REQ-018 SHALL ignore all presses in BLANK states; they are neither queued nor counted.
REQ-019 SHALL set digit_sel to 0 when entering BLANK_TO_SINGLE.
REQ-020 SHALL, in SINGLE on a next press, increment digit_sel modulo 8 (7 wraps to 0) and clear the timeout counter.
REQ-021 SHALL, in SINGLE on a mode press, enter BLANK_TO_FULL with digit_sel held.
REQ-022 SHALL give the mode press priority when mode and next presses coincide in SINGLE: the FSM enters BLANK_TO_FULL and digit_sel does not change.
REQ-023 SHALL count cycles in SINGLE with a timeout counter that clears on entry to SINGLE, and on reaching TIMEOUT_CYCLES-1 enter BLANK_TO_FULL exactly as for a mode press.
REQ-024 SHALL give a press the win over the timeout when both occur in the same cycle.
REQ-025 SHALL size the counters to hold their parameter values without overflow, using at least 32 bits for the timeout counter.

Reset
REQ-026 SHALL, while reset is high and in any state (including mid-blank), force FSM=FULL, mode=0, digit_sel=0, blank=0, mode_changed=0, clear all counters and set debounced levels and synchronizers to 0.
REQ-027 SHALL, after reset is released, treat a button already held as a new press once it is debounced.

Verification (bench parameters: DEBOUNCE_CYCLES=4, BLANK_CYCLES=3, TIMEOUT_CYCLES=50)
REQ-028 Clean press: btn_mode held high for 20 cycles -> blank rises 5-8 cycles after the input rises; mode goes 0->1 with mode_changed=1 one cycle later; blank falls 3 cycles after it rose; digit_sel=0.
REQ-029 Bounce rejection: btn_mode toggled every 2 cycles for 16 cycles, then held low -> mode stays 0, blank stays 0, mode_changed never pulses.
REQ-030 Digit wrap: in SINGLE, 9 separate clean btn_next presses -> digit_sel steps 1,2,...,7,0,1; mode stays 1.
REQ-031 Timeout: enter SINGLE, apply no press -> after 50 idle cycles blank asserts, mode returns to 0, and mode_changed pulses once; a next press at cycle 40 delays this to 50 cycles after that press.
REQ-032 Simultaneous press: in SINGLE with digit_sel=3, btn_mode and btn_next pressed together -> FSM goes to FULL, digit_sel stays 3, mode=0.
REQ-033 Reset mid-blank: assert reset in cycle 2 of BLANK_TO_SINGLE -> mode=0 and blank=0 immediately, without waiting for a clock edge; after release no mode_changed pulses until a new press.
